// File: rtl/video_pkt_pkg.sv
// Shared types and constants for the video-to-UDP packetiser.
package video_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR,
    ST_DATA
  } state_t;

  localparam logic [7:0]  HDR_MAGIC = 8'hA5;
  localparam int unsigned HDR_BYTES = 4;
  localparam int unsigned CNT_W     = 14;

  // UDP payload length: fixed header plus pixel bytes.
  function automatic logic [15:0] calc_tx_len(input int unsigned payload_bytes);
    return 16'(HDR_BYTES + payload_bytes);
  endfunction

endpackage

// File: rtl/video_packet_send.sv
// Streams pixel bytes from a FIFO into UDP packets, each prefixed with a
// 4-byte header carrying frame and packet counters.
module video_packet_send
  import video_pkt_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 1024
) (
  input  logic        video_rd_clk,
  input  logic        Reset_n,
  input  logic        video_rd_rdy,
  output logic        video_rd_en,
  input  logic [7:0]  video_rd_data,
  input  logic        frame_start,
  output logic        udp_tx_req,
  input  logic        udp_tx_ack,
  input  logic        udp_tx_data_req,
  output logic [7:0]  udp_tx_data,
  output logic [15:0] udp_tx_len,
  output logic        busy
);

  logic [1:0]       rst_sync;
  logic             rst_n;

  state_t           state, state_d;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_d;
  logic [15:0]      pkt_cnt, pkt_cnt_d;
  logic [7:0]       frame_cnt, frame_cnt_d;
  logic             pending, pending_d;
  logic [7:0]       data_q, data_d;
  logic             rd_pend, rd_pend_d;
  logic             req_d;

  // Asynchronous assert, synchronous release of the internal reset.
  always_ff @(posedge video_rd_clk or negedge Reset_n) begin
    if (!Reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge video_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      pkt_cnt    <= '0;
      frame_cnt  <= '0;
      pending    <= 1'b0;
      data_q     <= '0;
      rd_pend    <= 1'b0;
      udp_tx_req <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      byte_cnt   <= byte_cnt_d;
      pkt_cnt    <= pkt_cnt_d;
      frame_cnt  <= frame_cnt_d;
      pending    <= pending_d;
      data_q     <= data_d;
      rd_pend    <= rd_pend_d;
      udp_tx_req <= req_d;
      busy       <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d     = state;
    byte_cnt_d  = byte_cnt;
    pkt_cnt_d   = pkt_cnt;
    frame_cnt_d = frame_cnt;
    pending_d   = pending;
    data_d      = data_q;
    rd_pend_d   = 1'b0;
    req_d       = 1'b0;

    // FIFO byte arrives one cycle after its read; keep it for the hold value.
    if (rd_pend) data_d = video_rd_data;

    // A frame boundary seen mid-packet is deferred to packet completion.
    if (frame_start && (state != ST_IDLE)) pending_d = 1'b1;

    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          frame_cnt_d = frame_cnt + 8'd1;
          pkt_cnt_d   = '0;
        end
        if (video_rd_rdy) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (udp_tx_ack) state_d = ST_HDR;
      end
      ST_HDR: begin
        if (udp_tx_data_req) begin
          case (byte_cnt[1:0])
            2'd0:    data_d = HDR_MAGIC;
            2'd1:    data_d = frame_cnt;
            2'd2:    data_d = pkt_cnt[15:8];
            default: data_d = pkt_cnt[7:0];
          endcase
          if (byte_cnt == CNT_W'(HDR_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = ST_DATA;
          end else begin
            byte_cnt_d = byte_cnt + CNT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (udp_tx_data_req) begin
          rd_pend_d = 1'b1;
          if (byte_cnt == CNT_W'(PAYLOAD_BYTES - 1)) begin
            byte_cnt_d = '0;
            state_d    = ST_IDLE;
            pending_d  = 1'b0;
            if (pending || frame_start) begin
              frame_cnt_d = frame_cnt + 8'd1;
              pkt_cnt_d   = '0;
            end else begin
              pkt_cnt_d   = pkt_cnt + 16'd1;
            end
          end else begin
            byte_cnt_d = byte_cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_d = (state_d == ST_REQ);
  end

  // Same-cycle FIFO pop keeps header and payload latency both at one cycle.
  assign video_rd_en = (state == ST_DATA) && udp_tx_data_req;
  assign udp_tx_data = rd_pend ? video_rd_data : data_q;
  assign udp_tx_len  = calc_tx_len(PAYLOAD_BYTES);

endmodule

// File: tb/tb_video_packet_send.sv
// Directed bench for video_packet_send: header/payload stream, pacing,
// frame counting, counter wrap, stray requests and mid-packet reset.
module tb_video_packet_send;

  localparam int unsigned PAY = 1024;

  logic        video_rd_clk    = 1'b0;
  logic        Reset_n         = 1'b0;
  logic        video_rd_rdy    = 1'b0;
  logic        video_rd_en;
  logic [7:0]  video_rd_data   = 8'h00;
  logic        frame_start     = 1'b0;
  logic        udp_tx_req;
  logic        udp_tx_ack      = 1'b0;
  logic        udp_tx_data_req = 1'b0;
  logic [7:0]  udp_tx_data;
  logic [15:0] udp_tx_len;
  logic        busy;

  int          n_assert    = 0;
  int          n_fail      = 0;
  int          rd_cnt      = 0;
  int          rd_orphan   = 0;
  int          rd_at_abort = 0;
  logic [7:0]  fifo_ptr    = 8'h00;
  logic [7:0]  exp_byte    = 8'h00;

  video_packet_send #(.PAYLOAD_BYTES(PAY)) dut (
    .video_rd_clk    (video_rd_clk),
    .Reset_n         (Reset_n),
    .video_rd_rdy    (video_rd_rdy),
    .video_rd_en     (video_rd_en),
    .video_rd_data   (video_rd_data),
    .frame_start     (frame_start),
    .udp_tx_req      (udp_tx_req),
    .udp_tx_ack      (udp_tx_ack),
    .udp_tx_data_req (udp_tx_data_req),
    .udp_tx_data     (udp_tx_data),
    .udp_tx_len      (udp_tx_len),
    .busy            (busy)
  );

  always #5 video_rd_clk = ~video_rd_clk;

  // FIFO model: incrementing byte pattern, data valid the cycle after a pop.
  always @(posedge video_rd_clk) begin
    if (video_rd_en) begin
      rd_cnt        <= rd_cnt + 1;
      video_rd_data <= fifo_ptr;
      fifo_ptr      <= fifo_ptr + 8'd1;
      if (!udp_tx_data_req) rd_orphan <= rd_orphan + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic nclk;
    @(negedge video_rd_clk);
  endtask

  // Wait for udp_tx_req, optionally issue stray data requests, then ack.
  task automatic start_pkt(input int ack_dly, input bit stray);
    int k;
    k = 0;
    while (udp_tx_req !== 1'b1 && k < 200) begin
      nclk;
      k++;
    end
    check("tx_req_rise", 32'(udp_tx_req), 32'd1);
    for (int i = 0; i < ack_dly; i++) begin
      udp_tx_data_req = stray;
      nclk;
    end
    udp_tx_data_req = 1'b0;
    check("tx_req_held", 32'(udp_tx_req), 32'd1);
    udp_tx_ack = 1'b1;
    nclk;
    udp_tx_ack = 1'b0;
    check("tx_req_clear", 32'(udp_tx_req), 32'd0);
  endtask

  // Issue data requests every (gap+1) cycles and check header and payload.
  task automatic xfer(input logic [7:0] h1, input logic [7:0] h2, input logic [7:0] h3,
                      input int gap, input int fs_a, input int fs_b,
                      input bit tog, input int abort_at);
    int         bad, rd0, req_i, recv, total;
    bit         prev;
    logic [7:0] last;
    bad = 0; rd0 = rd_cnt; req_i = 0; recv = 0; prev = 1'b0; last = udp_tx_data;
    total = 4 + int'(PAY);
    for (int c = 0; c < total * (gap + 1) + 10; c++) begin
      if (prev) begin
        case (recv)
          0: check("hdr_magic", 32'(udp_tx_data), 32'h0000_00A5);
          1: check("hdr_frame", 32'(udp_tx_data), 32'(h1));
          2: check("hdr_pkt_hi", 32'(udp_tx_data), 32'(h2));
          3: check("hdr_pkt_lo", 32'(udp_tx_data), 32'(h3));
          default: begin
            if (udp_tx_data !== exp_byte) bad++;
            exp_byte = exp_byte + 8'd1;
          end
        endcase
        last = udp_tx_data;
        recv++;
      end else if (recv > 0 && udp_tx_data !== last) begin
        bad++;
      end
      if (recv == total) break;
      if (abort_at >= 0 && recv == abort_at) begin
        udp_tx_data_req = 1'b1;
        Reset_n         = 1'b0;
        #1;
        rd_at_abort = rd_cnt;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tx_req", 32'(udp_tx_req), 32'd0);
        check("abort_tx_data", 32'(udp_tx_data), 32'd0);
        check("abort_rd_en", 32'(video_rd_en), 32'd0);
        check("abort_reads", 32'(rd_cnt - rd0), 32'(abort_at - 4));
        return;
      end
      if (req_i < total && (c % (gap + 1)) == 0) begin
        udp_tx_data_req = 1'b1;
        req_i++;
        prev = 1'b1;
      end else begin
        udp_tx_data_req = 1'b0;
        prev = 1'b0;
      end
      frame_start = prev && (req_i == fs_a || req_i == fs_b);
      if (tog) video_rd_rdy = ((c % 2) == 1);
      nclk;
    end
    udp_tx_data_req = 1'b0;
    frame_start     = 1'b0;
    check("pkt_complete", 32'(recv), 32'(total));
    check("data_stream", 32'(bad), 32'd0);
    check("rd_en_count", 32'(rd_cnt - rd0), 32'(PAY));
    check("rd_en_orphan", 32'(rd_orphan), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    int         rd0;

    // Reset values
    nclk;
    nclk;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_req", 32'(udp_tx_req), 32'd0);
    check("rst_tx_data", 32'(udp_tx_data), 32'd0);
    check("rst_rd_en", 32'(video_rd_en), 32'd0);
    check("tx_len", 32'(udp_tx_len), 32'd1028);

    // Release: no request visible after the second edge
    video_rd_rdy = 1'b1;
    Reset_n      = 1'b1;
    nclk;
    nclk;
    check("release_latency", 32'(udp_tx_req), 32'd0);

    // Packet 0: contiguous, ack 3 cycles after req, ready dropped after ack
    start_pkt(3, 1'b0);
    video_rd_rdy = 1'b0;
    xfer(8'h00, 8'h00, 8'h00, 0, -1, -1, 1'b0, -1);

    // Packet 1: one request every third cycle
    video_rd_rdy = 1'b1;
    start_pkt(2, 1'b0);
    video_rd_rdy = 1'b0;
    xfer(8'h00, 8'h00, 8'h01, 2, -1, -1, 1'b0, -1);

    // Packet 2: stray requests while in REQ, ready held for back-to-back
    video_rd_rdy = 1'b1;
    start_pkt(2, 1'b1);
    xfer(8'h00, 8'h00, 8'h02, 0, -1, -1, 1'b0, -1);
    nclk;
    check("back_to_back_req", 32'(udp_tx_req), 32'd1);

    // Packet 3
    start_pkt(1, 1'b0);
    video_rd_rdy = 1'b0;
    xfer(8'h00, 8'h00, 8'h03, 0, -1, -1, 1'b0, -1);

    // Stray requests in IDLE
    rd0  = rd_cnt;
    held = udp_tx_data;
    for (int i = 0; i < 6; i++) begin
      udp_tx_data_req = ((i % 2) == 0);
      nclk;
    end
    udp_tx_data_req = 1'b0;
    check("idle_no_read", 32'(rd_cnt - rd0), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_hold", 32'(udp_tx_data), 32'(held));

    // Packet 4: two frame_starts mid-DATA
    video_rd_rdy = 1'b1;
    start_pkt(1, 1'b0);
    video_rd_rdy = 1'b0;
    xfer(8'h00, 8'h00, 8'h04, 0, 100, 600, 1'b0, -1);

    // Packet 5: single frame increment, ready toggling throughout
    video_rd_rdy = 1'b1;
    start_pkt(1, 1'b0);
    xfer(8'h01, 8'h00, 8'h00, 0, -1, -1, 1'b1, -1);
    video_rd_rdy = 1'b0;
    nclk;
    nclk;

    // Packet 6
    video_rd_rdy = 1'b1;
    start_pkt(1, 1'b0);
    video_rd_rdy = 1'b0;
    xfer(8'h01, 8'h00, 8'h01, 0, -1, -1, 1'b0, -1);

    // Frame counter to 8'hFF via IDLE frame_starts
    for (int i = 0; i < 254; i++) begin
      frame_start = 1'b1;
      nclk;
    end
    frame_start = 1'b0;
    video_rd_rdy = 1'b1;
    start_pkt(1, 1'b0);
    video_rd_rdy = 1'b0;
    xfer(8'hFF, 8'h00, 8'h00, 0, -1, -1, 1'b0, -1);

    // Wrap to 8'h00
    frame_start = 1'b1;
    nclk;
    frame_start = 1'b0;
    video_rd_rdy = 1'b1;
    start_pkt(1, 1'b0);
    video_rd_rdy = 1'b0;
    xfer(8'h00, 8'h00, 8'h00, 0, -1, -1, 1'b0, -1);

    // Reset at payload byte 500
    video_rd_rdy = 1'b1;
    start_pkt(1, 1'b0);
    video_rd_rdy = 1'b0;
    xfer(8'h00, 8'h00, 8'h01, 0, -1, -1, 1'b0, 504);
    for (int i = 0; i < 4; i++) nclk;
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) nclk;
    udp_tx_data_req = 1'b0;
    check("no_read_after_reset", 32'(rd_cnt), 32'(rd_at_abort));

    // First packet after reset starts counters afresh
    video_rd_rdy = 1'b1;
    start_pkt(1, 1'b0);
    video_rd_rdy = 1'b0;
    xfer(8'h00, 8'h00, 8'h00, 0, -1, -1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
